// File: rtl/ide_ctrl_pkg.sv
// ============================================================================
// Module : ide_ctrl_pkg
// Brief  : Shared state encoding, region constants and address decode helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ide_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_ACK     = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    localparam logic [1:0] REGION_ROM = 2'd0;
    localparam logic [1:0] REGION_CS0 = 2'd1;
    localparam logic [1:0] REGION_CS1 = 2'd2;

    function automatic logic [1:0] region_of(input logic a15, input logic a12);
        if (!a15)
            return REGION_ROM;
        return a12 ? REGION_CS1 : REGION_CS0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ide_sync.sv
// ============================================================================
// Module : ide_sync
// Brief  : Two-flop synchroniser that resets to logic 1 (idle strobe level).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ide_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ide_ctrl.sv
// ============================================================================
// Module : ide_ctrl
// Brief  : Zorro-II IDE task-file / boot-ROM bus cycle controller on C7M.
//          Define IDE_BOOTROM_EN to decode the boot ROM region (A15 = 0).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ide_ctrl
    import ide_ctrl_pkg::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int IORDY_MAX     = 15
) (
    input  logic         C7M,
    input  logic         RESET_n,
    input  logic [23:12] A,
    input  logic         AS_CPU_n,
    input  logic         DS_n,
    input  logic         RW_n,
    input  logic [7:0]   BASE_IDE,
    input  logic         IDE_CONFIGURED_n,
    input  logic         IDE_IORDY,
    output logic         IDE_CS0_n,
    output logic         IDE_CS1_n,
    output logic         IDE_DIOR_n,
    output logic         IDE_DIOW_n,
    output logic         ROM_OE_n,
    output logic         IDE_DTACK_n,
    output logic         IDE_ACCESS
);

    localparam int CW = 8;

    logic          as_s;
    logic          ds_s;
    state_t        state;
    logic [1:0]    region;
    logic          rd;
    logic [CW-1:0] cnt;
    logic [CW-1:0] wait_cnt;
    logic          addr_hit;
    logic          hit;
    logic [1:0]    dec_region;
    logic          unused_a;

    ide_sync u_as_sync (.clk(C7M), .rst_n(RESET_n), .d(AS_CPU_n), .q(as_s));
    ide_sync u_ds_sync (.clk(C7M), .rst_n(RESET_n), .d(DS_n),     .q(ds_s));

    assign unused_a   = ^A[14:13];
    assign dec_region = region_of(A[15], A[12]);
    assign addr_hit   = !IDE_CONFIGURED_n && (A[23:16] == BASE_IDE);
`ifdef IDE_BOOTROM_EN
    assign hit = addr_hit;
`else
    assign hit = addr_hit && A[15];
`endif

    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            state       <= S_IDLE;
            region      <= REGION_CS0;
            rd          <= 1'b1;
            cnt         <= '0;
            wait_cnt    <= '0;
            IDE_CS0_n   <= 1'b1;
            IDE_CS1_n   <= 1'b1;
            IDE_DIOR_n  <= 1'b1;
            IDE_DIOW_n  <= 1'b1;
            ROM_OE_n    <= 1'b1;
            IDE_DTACK_n <= 1'b1;
            IDE_ACCESS  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!as_s && hit) begin
                        state      <= S_SETUP;
                        region     <= dec_region;
                        rd         <= RW_n;
                        cnt        <= '0;
                        wait_cnt   <= '0;
                        IDE_ACCESS <= 1'b1;
                        IDE_CS0_n  <= (dec_region != REGION_CS0);
                        IDE_CS1_n  <= (dec_region != REGION_CS1);
                    end
                end
                S_SETUP: begin
                    if (as_s) begin
                        state <= S_RECOVER;
                    end else if (cnt < CW'(SETUP_CYCLES - 1)) begin
                        cnt <= cnt + 1'b1;
                    end else if (region == REGION_ROM) begin
                        state       <= S_ACK;
                        IDE_DTACK_n <= 1'b0;
`ifdef IDE_BOOTROM_EN
                        ROM_OE_n    <= !rd;
`endif
                    end else if (!ds_s) begin
                        // Data strobe gates the IDE strobe so write data is valid.
                        state      <= S_STROBE;
                        cnt        <= '0;
                        IDE_DIOR_n <= !rd;
                        IDE_DIOW_n <= rd;
                    end
                end
                S_STROBE: begin
                    if (as_s) begin
                        state <= S_RECOVER;
                    end else if (!IDE_IORDY && (wait_cnt < CW'(IORDY_MAX))) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end else if (cnt >= CW'(STROBE_CYCLES - 1)) begin
                        state       <= S_ACK;
                        IDE_DTACK_n <= 1'b0;
                        IDE_DIOW_n  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    if (as_s)
                        state <= S_RECOVER;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Aborts and normal completion share one release path.
            if ((state != S_IDLE) && (state != S_RECOVER) && as_s) begin
                IDE_CS0_n   <= 1'b1;
                IDE_CS1_n   <= 1'b1;
                IDE_DIOR_n  <= 1'b1;
                IDE_DIOW_n  <= 1'b1;
                ROM_OE_n    <= 1'b1;
                IDE_DTACK_n <= 1'b1;
                IDE_ACCESS  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ide_ctrl.sv
// ============================================================================
// Module : tb_ide_ctrl
// Brief  : Directed scoreboard bench for ide_ctrl (default parameters).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ide_ctrl;

    logic        C7M = 1'b0;
    logic        RESET_n = 1'b0;
    logic [23:12] A = '0;
    logic        AS_CPU_n = 1'b1;
    logic        DS_n = 1'b1;
    logic        RW_n = 1'b1;
    logic [7:0]  BASE_IDE = 8'hE9;
    logic        IDE_CONFIGURED_n = 1'b1;
    logic        IDE_IORDY = 1'b1;
    logic        IDE_CS0_n, IDE_CS1_n, IDE_DIOR_n, IDE_DIOW_n;
    logic        ROM_OE_n, IDE_DTACK_n, IDE_ACCESS;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [6:0] seen;      // {cs0,cs1,dior,diow,rom,access,dtack}
        logic [4:0] at_ack;    // {cs0_n,cs1_n,dior_n,diow_n,rom_oe_n} when DTACK asserts
        int         cs_edge;
        int         strobe_edge;
        int         strobe_len;
        int         dtack_edge;
        int         rel_edge;
    } exp_t;

    exp_t sb[$];

    ide_ctrl dut (
        .C7M(C7M), .RESET_n(RESET_n), .A(A), .AS_CPU_n(AS_CPU_n), .DS_n(DS_n),
        .RW_n(RW_n), .BASE_IDE(BASE_IDE), .IDE_CONFIGURED_n(IDE_CONFIGURED_n),
        .IDE_IORDY(IDE_IORDY), .IDE_CS0_n(IDE_CS0_n), .IDE_CS1_n(IDE_CS1_n),
        .IDE_DIOR_n(IDE_DIOR_n), .IDE_DIOW_n(IDE_DIOW_n), .ROM_OE_n(ROM_OE_n),
        .IDE_DTACK_n(IDE_DTACK_n), .IDE_ACCESS(IDE_ACCESS)
    );

    always #5 C7M = ~C7M;

    task automatic check(input string tag, input int got, input int want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic outs_idle();
        return IDE_CS0_n && IDE_CS1_n && IDE_DIOR_n && IDE_DIOW_n &&
               ROM_OE_n && IDE_DTACK_n && !IDE_ACCESS;
    endfunction

    function automatic exp_t mk(input logic [6:0] seen, input logic [4:0] at_ack,
                                input int cs_e, input int st_e, input int st_l,
                                input int dt_e, input int rel_e);
        exp_t e;
        e.seen = seen; e.at_ack = at_ack; e.cs_edge = cs_e; e.strobe_edge = st_e;
        e.strobe_len = st_l; e.dtack_edge = dt_e; e.rel_edge = rel_e;
        return e;
    endfunction

    // One CPU bus cycle; the expected record must already be queued.
    task automatic do_access(input string tag, input logic [23:0] addr, input logic rw,
                             input int ds_delay, input int iordy_low, input int max_cyc);
        exp_t       e;
        logic [6:0] seen = '0;
        logic [4:0] at_ack = 5'b11111;
        int cs_e = -1, st_e = -1, dt_e = -1, rel_e = -1, rem = 0, k;
        bit overlap = 0, idle_ok = 0;
        @(negedge C7M);
        A = addr[23:12]; RW_n = rw; AS_CPU_n = 1'b0; DS_n = (ds_delay == 0) ? 1'b0 : 1'b1;
        for (k = 1; k <= max_cyc; k++) begin
            @(posedge C7M); #1;
            if (k == ds_delay) DS_n = 1'b0;
            if ((!IDE_CS0_n && !IDE_CS1_n) || (!IDE_DIOR_n && !IDE_DIOW_n)) overlap = 1;
            seen |= {!IDE_CS0_n, !IDE_CS1_n, !IDE_DIOR_n, !IDE_DIOW_n, !ROM_OE_n,
                     IDE_ACCESS, !IDE_DTACK_n};
            if (cs_e < 0 && (!IDE_CS0_n || !IDE_CS1_n)) cs_e = k;
            if (st_e < 0 && (!IDE_DIOR_n || !IDE_DIOW_n)) begin
                st_e = k;
                if (iordy_low > 0) begin IDE_IORDY = 1'b0; rem = iordy_low; end
            end else if (rem > 0) begin
                rem--;
                if (rem == 0) IDE_IORDY = 1'b1;
            end
            if (!IDE_DTACK_n) begin
                dt_e = k;
                at_ack = {IDE_CS0_n, IDE_CS1_n, IDE_DIOR_n, IDE_DIOW_n, ROM_OE_n};
                break;
            end
        end
        AS_CPU_n = 1'b1; DS_n = 1'b1; IDE_IORDY = 1'b1;
        for (k = 1; k <= 8; k++) begin
            @(posedge C7M); #1;
            if ((!IDE_CS0_n && !IDE_CS1_n) || (!IDE_DIOR_n && !IDE_DIOW_n)) overlap = 1;
            if (rel_e < 0 && IDE_DTACK_n && dt_e > 0) rel_e = k;
            if (outs_idle()) begin idle_ok = 1; break; end
        end
        repeat (3) @(posedge C7M);
        e = sb.pop_front();
        check({tag, " seen"}, int'(seen), int'(e.seen));
        check({tag, " no_overlap"}, int'(overlap), 0);
        check({tag, " idle_after"}, int'(idle_ok), 1);
        if (e.seen[0]) begin
            check({tag, " dtack_edge"}, dt_e, e.dtack_edge);
            check({tag, " at_ack"}, int'(at_ack), int'(e.at_ack));
            check({tag, " release_edge"}, rel_e, e.rel_edge);
        end
        if (e.cs_edge >= 0) check({tag, " cs_edge"}, cs_e, e.cs_edge);
        if (e.strobe_edge >= 0) begin
            check({tag, " strobe_edge"}, st_e, e.strobe_edge);
            check({tag, " strobe_len"}, dt_e - st_e, e.strobe_len);
        end
    endtask

    initial begin
        int k;
        bit found;
        #12;
        check("reset idle", int'(outs_idle()), 1);
        @(negedge C7M); RESET_n = 1'b1;
        repeat (2) @(negedge C7M);

        // Unconfigured card ignores its own base address.
        sb.push_back(mk(7'b0, 5'b11111, -1, -1, 0, -1, -1));
        do_access("unconfigured", 24'hE98000, 1'b1, 0, 0, 12);
        IDE_CONFIGURED_n = 1'b0;

        sb.push_back(mk(7'b1010011, 5'b01011, 3, 4, 2, 6, 3));
        do_access("read_cs0", 24'hE98000, 1'b1, 0, 0, 40);

        sb.push_back(mk(7'b0101011, 5'b10111, 3, 7, 2, 9, 3));
        do_access("write_cs1_ds4", 24'hE99000, 1'b0, 4, 0, 40);

        sb.push_back(mk(7'b1010011, 5'b01011, 3, 4, 7, 11, 3));
        do_access("read_iordy5", 24'hE98000, 1'b1, 0, 5, 40);

        sb.push_back(mk(7'b1010011, 5'b01011, 3, 4, 17, 21, 3));
        do_access("read_iordy_stuck", 24'hE98000, 1'b1, 0, 1000, 60);

        sb.push_back(mk(7'b0, 5'b11111, -1, -1, 0, -1, -1));
        do_access("wrong_base", 24'hEA8000, 1'b1, 0, 0, 12);

`ifdef IDE_BOOTROM_EN
        sb.push_back(mk(7'b0000111, 5'b11110, -1, -1, 0, 4, 3));
        do_access("rom_read", 24'hE90000, 1'b1, 0, 0, 20);
        sb.push_back(mk(7'b0000011, 5'b11111, -1, -1, 0, 4, 3));
        do_access("rom_write", 24'hE90000, 1'b0, 0, 0, 20);
`else
        sb.push_back(mk(7'b0, 5'b11111, -1, -1, 0, -1, -1));
        do_access("rom_disabled", 24'hE90000, 1'b1, 0, 0, 12);
`endif

        // Reset asserted while the read strobe is held by IORDY.
        @(negedge C7M);
        A = 12'hE98; RW_n = 1'b1; AS_CPU_n = 1'b0; DS_n = 1'b0; IDE_IORDY = 1'b0;
        found = 0;
        for (k = 0; k < 12; k++) begin
            @(posedge C7M); #1;
            if (!IDE_DIOR_n) begin found = 1; break; end
        end
        check("rst_mid reach strobe", int'(found), 1);
        @(posedge C7M); #1;
        RESET_n = 1'b0;
        #1;
        check("rst_mid async idle", int'(outs_idle()), 1);
        AS_CPU_n = 1'b1; DS_n = 1'b1; IDE_IORDY = 1'b1;
        repeat (2) @(negedge C7M);
        RESET_n = 1'b1;
        repeat (3) @(negedge C7M);
        check("rst_mid idle after release", int'(outs_idle()), 1);

        sb.push_back(mk(7'b1010011, 5'b01011, 3, 4, 2, 6, 3));
        do_access("read_after_reset", 24'hE98000, 1'b1, 0, 0, 40);

        check("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
